// File: rtl/i2c_reg_slave_if.sv
// I2C pad signals and register-file port of i2c_reg_slave.
// The slave modport is used by the design; master by whatever drives the bus.
interface i2c_reg_slave_if #(
  parameter int unsigned NUM_REGS = 16
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic          scl_i;
  logic          scl_o;
  logic          sda_i;
  logic          sda_o;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic [7:0]    reg_rdata;
  logic          start;
  logic          stop;

  modport slave (
    input  scl_i, sda_i, reg_rdata,
    output scl_o, sda_o, reg_addr, reg_wdata, reg_we, start, stop
  );

  modport master (
    output scl_i, sda_i, reg_rdata,
    input  scl_o, sda_o, reg_addr, reg_wdata, reg_we, start, stop
  );
endinterface

// File: rtl/i2c_reg_slave.sv
// I2C slave with a register pointer and auto-incrementing register-file writes.
// Define I2C_READBACK_EN to add readback of the register file over I2C reads.
module i2c_reg_slave #(
  parameter logic [6:0]  ADDRESS    = 7'h4A,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned FILTER_LEN = 4
) (
  input logic            clk,
  input logic            reset,
  i2c_reg_slave_if.slave bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    StIdle, StAddr, StPtr, StWdata, StWaitStop
`ifdef I2C_READBACK_EN
    , StRdata
`endif
  } state_e;

  // Index 0 is SCL, index 1 is SDA.
  logic [1:0]    r_sync1, r_sync2, r_filt, r_prev;
  logic [FW-1:0] r_fcnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_filt  <= 2'b11;
      r_prev  <= 2'b11;
      r_fcnt  <= '{default: '0};
    end else begin
      r_sync1 <= {bus.sda_i, bus.scl_i};
      r_sync2 <= r_sync1;
      r_prev  <= r_filt;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_filt[i] <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FW'(1);
        end
      end
    end
  end

  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  assign w_scl_rise = r_filt[0] & ~r_prev[0];
  assign w_scl_fall = ~r_filt[0] & r_prev[0];
  assign w_start    = r_filt[0] & r_prev[0] & r_prev[1] & ~r_filt[1];
  assign w_stop     = r_filt[0] & r_prev[0] & ~r_prev[1] & r_filt[1];

  state_e        r_state, r_pend, w_state_d, w_pend_d;
  logic [3:0]    r_bit_cnt, w_bit_cnt_d;
  logic [7:0]    r_shift, w_shift_d, r_reg_wdata, w_reg_wdata_d;
  logic [AW-1:0] r_reg_addr, w_reg_addr_d, w_addr_inc;
  logic          r_sda_o, w_sda_o_d, r_reg_we, w_reg_we_d, r_inc, w_inc_d;
  logic          r_start, w_start_d, r_stop, w_stop_d;
  logic [7:0]    w_byte;

  assign w_byte     = {r_shift[6:0], r_filt[1]};
  assign w_addr_inc = (r_reg_addr == AW'(NUM_REGS - 1)) ? '0 : r_reg_addr + AW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_pend      <= StIdle;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_sda_o     <= 1'b1;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
      r_reg_we    <= 1'b0;
      r_inc       <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_pend      <= w_pend_d;
      r_bit_cnt   <= w_bit_cnt_d;
      r_shift     <= w_shift_d;
      r_sda_o     <= w_sda_o_d;
      r_reg_addr  <= w_reg_addr_d;
      r_reg_wdata <= w_reg_wdata_d;
      r_reg_we    <= w_reg_we_d;
      r_inc       <= w_inc_d;
      r_start     <= w_start_d;
      r_stop      <= w_stop_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_pend_d      = r_pend;
    w_bit_cnt_d   = r_bit_cnt;
    w_shift_d     = r_shift;
    w_sda_o_d     = r_sda_o;
    w_reg_addr_d  = r_reg_addr;
    w_reg_wdata_d = r_reg_wdata;
    w_reg_we_d    = 1'b0;
    w_inc_d       = 1'b0;
    w_start_d     = 1'b0;
    w_stop_d      = 1'b0;
    // Post-write increment lands one cycle after the reg_we strobe.
    if (r_inc) w_reg_addr_d = w_addr_inc;
    if (w_start) begin
      w_start_d   = 1'b1;
      w_state_d   = StAddr;
      w_bit_cnt_d = '0;
      w_sda_o_d   = 1'b1;
    end else if (w_stop) begin
      w_stop_d    = 1'b1;
      w_state_d   = StIdle;
      w_bit_cnt_d = '0;
      w_sda_o_d   = 1'b1;
    end else begin
      unique case (r_state)
        StAddr, StPtr, StWdata: begin
          if (w_scl_rise) begin
            if (r_bit_cnt < 4'd8) begin
              w_shift_d   = w_byte;
              w_bit_cnt_d = r_bit_cnt + 4'd1;
              // NACK goes straight to StWaitStop; ACK waits for the ACK bit's falling edge.
              if (r_bit_cnt == 4'd7) begin
                w_state_d = StWaitStop;
                if (r_state == StAddr && w_byte[7:1] == ADDRESS) begin
                  if (!w_byte[0]) begin
                    w_state_d = r_state;
                    w_pend_d  = StPtr;
                  end
`ifdef I2C_READBACK_EN
                  else begin
                    w_state_d = r_state;
                    w_pend_d  = StRdata;
                  end
`endif
                end else if (r_state == StPtr && 32'(w_byte) < NUM_REGS) begin
                  w_state_d    = r_state;
                  w_pend_d     = StWdata;
                  w_reg_addr_d = w_byte[AW-1:0];
                end else if (r_state == StWdata) begin
                  w_state_d     = r_state;
                  w_pend_d      = StWdata;
                  w_reg_wdata_d = w_byte;
                  w_reg_we_d    = 1'b1;
                  w_inc_d       = 1'b1;
                end
              end
            end else if (r_bit_cnt == 4'd8) begin
              w_bit_cnt_d = 4'd9;
            end
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_o_d = 1'b0;
            end else if (r_bit_cnt == 4'd9) begin
              w_sda_o_d   = 1'b1;
              w_bit_cnt_d = '0;
              w_state_d   = r_pend;
`ifdef I2C_READBACK_EN
              if (r_pend == StRdata) begin
                w_shift_d = bus.reg_rdata;
                w_sda_o_d = bus.reg_rdata[7];
              end
`endif
            end
          end
        end
`ifdef I2C_READBACK_EN
        StRdata: begin
          if (w_scl_rise) begin
            if (r_bit_cnt < 4'd8) begin
              w_bit_cnt_d = r_bit_cnt + 4'd1;
            end else if (r_bit_cnt == 4'd8) begin
              if (!r_filt[1]) begin
                w_bit_cnt_d  = 4'd9;
                w_reg_addr_d = w_addr_inc;
              end else begin
                w_state_d = StWaitStop;
              end
            end
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_o_d = 1'b1;
            end else if (r_bit_cnt == 4'd9) begin
              w_shift_d   = bus.reg_rdata;
              w_sda_o_d   = bus.reg_rdata[7];
              w_bit_cnt_d = '0;
            end else if (r_bit_cnt != 4'd0) begin
              w_shift_d = {r_shift[6:0], 1'b0};
              w_sda_o_d = r_shift[6];
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef I2C_READBACK_EN
  logic w_unused;
  assign w_unused = ^{bus.reg_rdata, r_shift[7]};
`endif

  assign bus.scl_o     = 1'b1;
  assign bus.sda_o     = r_sda_o;
  assign bus.reg_addr  = r_reg_addr;
  assign bus.reg_wdata = r_reg_wdata;
  assign bus.reg_we    = r_reg_we;
  assign bus.start     = r_start;
  assign bus.stop      = r_stop;
endmodule
